// File: rtl/arb_pkg.sv
// arb_pkg: state encoding and shared constants for sram_bus_arbiter
package arb_pkg;
  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_BUSY_D = 2'd1,
    ARB_BUSY_I = 2'd2,
    ARB_DONE   = 2'd3
  } arb_state_t;
  localparam logic [31:0] ZERO_WORD = 32'h0;
  localparam logic [3:0]  IF_SEL    = 4'hF;
endpackage

// File: rtl/arb_timeout_cnt.sv
// arb_timeout_cnt: busy-cycle counter, expired on the cycle that would reach limit
module arb_timeout_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         inc,
  input  logic [W-1:0] limit,
  output logic         expired
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (clear) cnt <= '0;
    else if (inc) cnt <= cnt + 1'b1;
  assign expired = cnt == limit - 1'b1;
endmodule

// File: rtl/sram_bus_arbiter.sv
// sram_bus_arbiter: D-over-IF memory bus arbiter; ARB_TIMEOUT_EN adds busy timeout abort with bus_err
module sram_bus_arbiter
  import arb_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [3:0]        d_sel,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              m_req,
  output logic              m_we,
  output logic [3:0]        m_sel,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_ack,
  output logic              bus_err
);
  arb_state_t state;
  logic busy, tmo;
  logic [DATA_W-1:0] rd;
  assign busy = state == ARB_BUSY_D || state == ARB_BUSY_I;
  assign rd = m_ack && !m_we ? m_rdata : DATA_W'(ZERO_WORD);
`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic expired;
  arb_timeout_cnt #(.W(CW)) u_tmo (
    .clk(clk),
    .rst(rst),
    .clear(!busy),
    .inc(busy && !m_ack),
    .limit(CW'(TIMEOUT_CYCLES)),
    .expired(expired)
  );
  assign tmo = busy && expired;
`else
  assign tmo = TIMEOUT_CYCLES < 0;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state    <= ARB_IDLE;
      m_req    <= 1'b0;
      m_we     <= 1'b0;
      m_sel    <= '0;
      m_addr   <= '0;
      m_wdata  <= '0;
      if_rdata <= '0;
      d_rdata  <= '0;
      if_ack   <= 1'b0;
      d_ack    <= 1'b0;
      bus_err  <= 1'b0;
    end else begin
      if_ack  <= 1'b0;
      d_ack   <= 1'b0;
      bus_err <= 1'b0;
      case (state)
        ARB_IDLE:
          if (d_req) begin
            m_req   <= 1'b1;
            m_we    <= d_we;
            m_sel   <= d_sel;
            m_addr  <= d_addr;
            m_wdata <= d_wdata;
            state   <= ARB_BUSY_D;
          end else if (if_req) begin
            m_req   <= 1'b1;
            m_we    <= 1'b0;
            m_sel   <= IF_SEL;
            m_addr  <= if_addr;
            m_wdata <= DATA_W'(ZERO_WORD);
            state   <= ARB_BUSY_I;
          end
        ARB_BUSY_D, ARB_BUSY_I:
          if (m_ack || tmo) begin
            state   <= ARB_DONE;
            m_req   <= 1'b0;
            bus_err <= !m_ack;
            if (state == ARB_BUSY_D) begin
              d_ack   <= 1'b1;
              d_rdata <= rd;
            end else begin
              if_ack   <= 1'b1;
              if_rdata <= rd;
            end
          end
        default: state <= ARB_IDLE;
      endcase
    end
endmodule
